// File: rtl/fifo_join_nch.sv
// N-channel buffered join: per-channel input FIFOs feed a reduction (sum, XOR or max)
// over the enabled channels, and the result is queued in an output FIFO.
module fifo_join_nch #(
  parameter int N_CH    = 2,
  parameter int D_WIDTH = 6,
  parameter int A_WIDTH = 2,
  parameter int MODE    = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_CH*D_WIDTH-1:0]   up_data,
  input  logic [N_CH-1:0]           up_valid,
  output logic [N_CH-1:0]           up_ready,
  input  logic [N_CH-1:0]           ch_en,
  output logic [D_WIDTH-1:0]        down_data,
  output logic                      down_valid,
  input  logic                      down_ready,
  output logic [15:0]               join_count
);

  localparam int               DEPTH    = 1 << A_WIDTH;
  localparam int               ACC_W    = D_WIDTH + 3;
  localparam logic [A_WIDTH:0] FULL_CNT = (A_WIDTH + 1)'(DEPTH);
  localparam logic [A_WIDTH:0] CNT_ONE  = (A_WIDTH + 1)'(1);
  localparam logic [A_WIDTH-1:0] PTR_ONE = A_WIDTH'(1);

  logic [N_CH-1:0]         in_push;
  logic [N_CH-1:0]         in_pop;
  logic [N_CH-1:0]         in_full;
  logic [N_CH-1:0]         in_empty;
  logic [N_CH*D_WIDTH-1:0] in_head;

  logic                    vld_p0;
  logic [D_WIDTH-1:0]      join_res_p0;

  logic                    out_push;
  logic                    out_pop;
  logic                    out_full;
  logic                    out_empty;
  logic [D_WIDTH-1:0]      out_mem [DEPTH];
  logic [A_WIDTH-1:0]      out_wptr;
  logic [A_WIDTH-1:0]      out_rptr;
  logic [A_WIDTH:0]        out_cnt;

  // Only enabled heads contribute; a single enabled channel passes through unchanged.
  function automatic logic [D_WIDTH-1:0] reduce_heads(
    input logic [N_CH*D_WIDTH-1:0] heads,
    input logic [N_CH-1:0]         en
  );
    logic [ACC_W-1:0]   acc;
    logic [D_WIDTH-1:0] x;
    logic [D_WIDTH-1:0] m;
    logic [D_WIDTH-1:0] h;
    acc = '0;
    x   = '0;
    m   = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (en[i]) begin
        h   = heads[i*D_WIDTH +: D_WIDTH];
        acc = acc + ACC_W'(h);
        x   = x ^ h;
        if (h > m) m = h;
      end
    end
    if (MODE == 1)      return x;
    else if (MODE == 2) return m;
    else                return acc[D_WIDTH-1:0];
  endfunction

  // Stage 0: per-channel input FIFOs
  for (genvar i = 0; i < N_CH; i++) begin : g_in
    logic [D_WIDTH-1:0] mem [DEPTH];
    logic [A_WIDTH-1:0] wptr;
    logic [A_WIDTH-1:0] rptr;
    logic [A_WIDTH:0]   cnt;

    assign in_full[i]  = (cnt == FULL_CNT);
    assign in_empty[i] = (cnt == '0);
    assign in_push[i]  = up_valid[i] && !in_full[i];
    assign in_pop[i]   = vld_p0 && ch_en[i];
    assign in_head[i*D_WIDTH +: D_WIDTH] = mem[rptr];

    always_ff @(posedge clk) begin
      if (rst) begin
        wptr <= '0;
        rptr <= '0;
        cnt  <= '0;
      end else begin
        if (in_push[i]) wptr <= wptr + PTR_ONE;
        if (in_pop[i])  rptr <= rptr + PTR_ONE;
        case ({in_push[i], in_pop[i]})
          2'b10:   cnt <= cnt + CNT_ONE;
          2'b01:   cnt <= cnt - CNT_ONE;
          default: cnt <= cnt;
        endcase
      end
    end

    always_ff @(posedge clk) begin
      if (in_push[i]) mem[wptr] <= up_data[i*D_WIDTH +: D_WIDTH];
    end
  end

  assign up_ready = ~in_full;

  // Join decision: every enabled channel must hold a word and the output must have room
  assign vld_p0      = (|ch_en) && (&(~in_empty | ~ch_en)) && !out_full;
  assign join_res_p0 = reduce_heads(in_head, ch_en);

  // Stage 1: output FIFO and join counter
  assign out_full  = (out_cnt == FULL_CNT);
  assign out_empty = (out_cnt == '0);
  assign out_push  = vld_p0;
  assign out_pop   = !out_empty && down_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_wptr   <= '0;
      out_rptr   <= '0;
      out_cnt    <= '0;
      join_count <= '0;
    end else begin
      if (out_push) begin
        out_wptr   <= out_wptr + PTR_ONE;
        join_count <= join_count + 16'd1;
      end
      if (out_pop) out_rptr <= out_rptr + PTR_ONE;
      case ({out_push, out_pop})
        2'b10:   out_cnt <= out_cnt + CNT_ONE;
        2'b01:   out_cnt <= out_cnt - CNT_ONE;
        default: out_cnt <= out_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (out_push) out_mem[out_wptr] <= join_res_p0;
  end

  // The head is forced to zero while empty so stale words never leak after reset.
  assign down_valid = !out_empty;
  assign down_data  = out_empty ? '0 : out_mem[out_rptr];

endmodule

// File: tb/tb_fifo_join_nch.sv
// Bench for fifo_join_nch: three instances (sum, XOR, max) share one 3-channel stimulus.
module tb_fifo_join_nch;

  localparam int N     = 3;
  localparam int DW    = 6;
  localparam int AW    = 2;
  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [N*DW-1:0] up_data;
  logic [N-1:0]    up_valid;
  logic [N-1:0]    ch_en;
  logic            down_ready;
  logic [N-1:0]    up_ready   [3];
  logic [DW-1:0]   down_data  [3];
  logic            down_valid [3];
  logic [15:0]     join_count [3];

  always #5 clk = ~clk;

  for (genvar m = 0; m < 3; m++) begin : g_dut
    fifo_join_nch #(.N_CH(N), .D_WIDTH(DW), .A_WIDTH(AW), .MODE(m)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .up_data    (up_data),
      .up_valid   (up_valid),
      .up_ready   (up_ready[m]),
      .ch_en      (ch_en),
      .down_data  (down_data[m]),
      .down_valid (down_valid[m]),
      .down_ready (down_ready),
      .join_count (join_count[m])
    );
  end

  int n_vec = 0;
  int n_err = 0;

  // reference model state
  int mbuf [N][DEPTH];
  int mhead [N];
  int mcnt [N];
  int ores [3][DEPTH];
  int ohead, ocnt, mcount, mtotal;

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    n_vec++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    bit       fire;
    bit       opop;
    bit [N-1:0] mfull;
    int s, x, mx, h, wp;
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        mhead[i] = 0;
        mcnt[i]  = 0;
      end
      ohead = 0; ocnt = 0; mcount = 0; mtotal = 0;
      return;
    end
    for (int i = 0; i < N; i++) mfull[i] = (mcnt[i] == DEPTH);
    fire = (ch_en != 0) && (ocnt != DEPTH);
    for (int i = 0; i < N; i++) if (ch_en[i] && mcnt[i] == 0) fire = 0;
    opop = (ocnt != 0) && down_ready;
    if (opop) begin
      ohead = (ohead + 1) % DEPTH;
      ocnt--;
    end
    if (fire) begin
      s = 0; x = 0; mx = 0;
      for (int i = 0; i < N; i++) begin
        if (ch_en[i]) begin
          h = mbuf[i][mhead[i]];
          s = s + h;
          x = x ^ h;
          if (h > mx) mx = h;
          mhead[i] = (mhead[i] + 1) % DEPTH;
          mcnt[i]--;
        end
      end
      wp = (ohead + ocnt) % DEPTH;
      ores[0][wp] = s % 64;
      ores[1][wp] = x;
      ores[2][wp] = mx;
      ocnt++;
      mcount = (mcount + 1) % 65536;
      mtotal++;
    end
    for (int i = 0; i < N; i++) begin
      if (up_valid[i] && !mfull[i]) begin
        mbuf[i][(mhead[i] + mcnt[i]) % DEPTH] = int'(up_data[i*DW +: DW]);
        mcnt[i]++;
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int i, input int v);
    up_data[i*DW +: DW] = v[DW-1:0];
  endtask

  task automatic chk_ctl(input string tag, input int rdy, input int dv, input int jc);
    for (int m = 0; m < 3; m++) begin
      check($sformatf("%s_rdy%0d", tag, m), 32'(up_ready[m]), rdy);
      check($sformatf("%s_vld%0d", tag, m), 32'(down_valid[m]), dv);
      check($sformatf("%s_cnt%0d", tag, m), 32'(join_count[m]), jc);
    end
  endtask

  task automatic chk_data(input string tag, input int s, input int x, input int mx);
    check($sformatf("%s_sum", tag), 32'(down_data[0]), s);
    check($sformatf("%s_xor", tag), 32'(down_data[1]), x);
    check($sformatf("%s_max", tag), 32'(down_data[2]), mx);
  endtask

  task automatic check_model(input string tag);
    int exp_rdy;
    exp_rdy = 0;
    for (int i = 0; i < N; i++) if (mcnt[i] != DEPTH) exp_rdy = exp_rdy | (1 << i);
    for (int m = 0; m < 3; m++) begin
      check($sformatf("%s_rdy%0d", tag, m), 32'(up_ready[m]), exp_rdy);
      check($sformatf("%s_vld%0d", tag, m), 32'(down_valid[m]), 32'(ocnt != 0));
      check($sformatf("%s_dat%0d", tag, m), 32'(down_data[m]), (ocnt != 0) ? ores[m][ohead] : 0);
      check($sformatf("%s_cnt%0d", tag, m), 32'(join_count[m]), mcount);
    end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bp_sum [8] = '{27, 30, 33, 36, 39, 42, 45, 48};
    int bp_xor [8] = '{25, 26, 27, 28, 29, 30, 31, 0};
    int bp_max [8] = '{17, 18, 19, 20, 21, 22, 23, 24};
    int got;
    logic [15:0] jc0;

    rst = 1'b1; up_data = '0; up_valid = '0; ch_en = '0; down_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk_ctl("reset", 7, 0, 0);
    chk_data("reset", 0, 0, 0);

    // basic two-channel join
    ch_en = 3'b011; down_ready = 1'b1;
    set_ch(0, 'h05); set_ch(1, 'h3E); up_valid = 3'b011;
    tick();
    up_valid = '0;
    chk_ctl("basic_early", 7, 0, 0);
    tick();
    chk_ctl("basic", 7, 1, 1);
    chk_data("basic", 'h03, 'h3B, 'h3E);
    tick();
    chk_ctl("basic_drain", 7, 0, 1);

    // skewed arrival on three channels
    ch_en = 3'b111;
    set_ch(0, 'h10); up_valid = 3'b001; tick(); up_valid = '0;
    chk_ctl("skew_t0", 7, 0, 1);
    tick(); tick();
    chk_ctl("skew_t2", 7, 0, 1);
    set_ch(1, 'h2A); up_valid = 3'b010; tick(); up_valid = '0;
    chk_ctl("skew_t3", 7, 0, 1);
    tick();
    set_ch(2, 'h07); up_valid = 3'b100; tick(); up_valid = '0;
    chk_ctl("skew_t5", 7, 0, 1);
    tick();
    chk_ctl("skew_out", 7, 1, 2);
    chk_data("skew_out", 'h01, 'h3D, 'h2A);
    tick();
    chk_ctl("skew_drain", 7, 0, 2);

    // channel mask 101, channel 1 idle
    ch_en = 3'b101;
    set_ch(0, 1); set_ch(2, 3); up_valid = 3'b101; tick();
    set_ch(0, 2); set_ch(2, 3); tick();
    up_valid = '0;
    chk_ctl("mask_a", 7, 1, 3);
    chk_data("mask_a", 'h04, 'h02, 'h03);
    tick();
    chk_ctl("mask_b", 7, 1, 4);
    chk_data("mask_b", 'h05, 'h01, 'h03);
    tick();
    chk_ctl("mask_end", 7, 0, 4);
    set_ch(1, 'h15); up_valid = 3'b010;
    repeat (4) tick();
    chk_ctl("ch1_full", 5, 0, 4);
    tick();
    chk_ctl("ch1_blocked", 5, 0, 4);
    up_valid = '0;

    // no channels enabled: nothing joins
    ch_en = '0;
    set_ch(0, 'h11); set_ch(2, 'h22); up_valid = 3'b101;
    tick(); tick();
    up_valid = '0;
    tick();
    chk_ctl("en_zero", 5, 0, 4);

    // reset with words buffered in every FIFO
    ch_en = 3'b101; down_ready = 1'b0;
    tick(); tick();
    chk_ctl("pre_rst", 5, 1, 6);
    chk_data("pre_rst", 'h33, 'h33, 'h22);
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    chk_ctl("mid_rst", 7, 0, 0);
    chk_data("mid_rst", 0, 0, 0);
    ch_en = 3'b010; down_ready = 1'b1;
    repeat (4) tick();
    chk_ctl("rst_flush", 7, 0, 0);

    // backpressure: fill output, then inputs
    ch_en = 3'b111; down_ready = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      if (k <= 8) begin
        set_ch(0, k); set_ch(1, k + 8); set_ch(2, k + 16);
      end else begin
        set_ch(0, 'h3F); set_ch(1, 'h3F); set_ch(2, 'h3F);
      end
      up_valid = 3'b111;
      tick();
    end
    up_valid = '0;
    chk_ctl("bp_full", 0, 1, 4);
    chk_data("bp_head", bp_sum[0], bp_xor[0], bp_max[0]);
    tick();
    chk_data("bp_hold", bp_sum[0], bp_xor[0], bp_max[0]);
    down_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 40 && got < 8; c++) begin
      if (down_valid[0]) begin
        chk_data($sformatf("drain%0d", got), bp_sum[got], bp_xor[got], bp_max[got]);
        got++;
      end
      tick();
    end
    check("drain_count", got, 8);
    chk_ctl("drain_end", 7, 0, 8);

    // random traffic against the model
    rst = 1'b1; tick(); rst = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      up_data    = 18'($urandom);
      up_valid   = 3'($urandom_range(0, 7));
      ch_en      = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'b111;
      down_ready = ($urandom_range(0, 2) != 0);
      tick();
      check_model("rnd");
    end

    // sustained streaming through the join counter wrap
    ch_en = 3'b111; up_valid = 3'b111; down_ready = 1'b1;
    jc0 = '0;
    for (int c = 0; c < 90000 && mtotal < 70000; c++) begin
      up_data = 18'($urandom);
      tick();
      check_model("sus");
      if (c == 100) jc0 = join_count[0];
      if (c == 1100) check("throughput", 32'(16'(join_count[0] - jc0)), 1000);
    end
    check("sustain_total", mtotal, 70000);
    ch_en = '0; up_valid = '0;
    for (int m = 0; m < 3; m++) check($sformatf("wrap_cnt%0d", m), 32'(join_count[m]), 4464);
    repeat (6) begin
      tick();
      check_model("tail");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
